// File: rtl/ps_paket.sv
// ---------------------------------------------------------------------------
// ps_paket
//  Shared definitions for the multi-slot fetch PC generator:
//   - ps_durum_e  : FSM states of the PC generator (BASLAT, GETIR, HATA)
//   - BUYRUK_BAYT : bytes per instruction slot
//   - MASKE_MAX   : widest slot mask the helper can build
//   - yuva_maske  : builds the per-slot valid mask of a fetch block
// ---------------------------------------------------------------------------
package ps_paket;

  localparam int BUYRUK_BAYT = 4;
  localparam int MASKE_MAX   = 32;

  typedef enum logic [1:0] {
    BASLAT = 2'd0,
    GETIR  = 2'd1,
    HATA   = 2'd2
  } ps_durum_e;

  // Slot i is live when it is at or after the PC's slot inside the block and,
  // if a taken branch is predicted, not after the branch slot.
  function automatic logic [MASKE_MAX-1:0] yuva_maske(input int   gg,
                                                       input int   ofs,
                                                       input logic ongoru,
                                                       input int   yuva);
    logic [MASKE_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < MASKE_MAX; i++) begin
      if ((i < gg) && (i >= ofs) && (!ongoru || (i <= yuva))) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/ps_yigin.sv
// ---------------------------------------------------------------------------
// ps_yigin
//  Return-address stack for the fetch PC generator. Circular storage: a push
//  into a full stack overwrites the oldest entry. A simultaneous pop+push
//  replaces the top entry (pop first, then push).
//  Ports:
//   clk_i       in  clock
//   rst_i       in  synchronous reset, active-high (empties the stack)
//   it_i        in  push request
//   cek_i       in  pop request (ignored when empty)
//   it_adres_i  in  address to push
//   ust_o       out current top entry (meaningless when bos_o=1)
//   bos_o       out stack empty
// ---------------------------------------------------------------------------
module ps_yigin #(
  parameter int ADRES_GENISLIGI = 32,
  parameter int DERINLIK        = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       it_i,
  input  logic                       cek_i,
  input  logic [ADRES_GENISLIGI-1:0] it_adres_i,
  output logic [ADRES_GENISLIGI-1:0] ust_o,
  output logic                       bos_o
);

  localparam int PW = (DERINLIK > 1) ? $clog2(DERINLIK) : 1;

  logic [ADRES_GENISLIGI-1:0] bellek [DERINLIK];
  logic [PW-1:0]              isaretci;   // next free slot
  logic [PW:0]                sayac;
  logic [PW-1:0]              ust_idx;
  logic                       dolu;

  function automatic logic [PW-1:0] ileri(input logic [PW-1:0] p);
    return (p == PW'(DERINLIK - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] geri(input logic [PW-1:0] p);
    return (p == '0) ? PW'(DERINLIK - 1) : p - 1'b1;
  endfunction

  always_comb begin
    ust_idx = geri(isaretci);
    ust_o   = bellek[ust_idx];
    bos_o   = (sayac == '0);
    dolu    = (sayac == (PW+1)'(DERINLIK));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      isaretci <= '0;
      sayac    <= '0;
    end else if (it_i && cek_i) begin
      // Pop+push on a non-empty stack just rewrites the top in place.
      if (bos_o) begin
        isaretci <= ileri(isaretci);
        sayac    <= (PW+1)'(1);
      end
    end else if (it_i) begin
      isaretci <= ileri(isaretci);
      if (!dolu) sayac <= sayac + 1'b1;
    end else if (cek_i && !bos_o) begin
      isaretci <= geri(isaretci);
      sayac    <= sayac - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (it_i) begin
      if (cek_i && !bos_o) bellek[ust_idx]  <= it_adres_i;
      else                 bellek[isaretci] <= it_adres_i;
    end
  end

endmodule

// File: rtl/ps_uretici_blok.sv
// ---------------------------------------------------------------------------
// ps_uretici_blok
//  Multi-slot fetch PC generator. Issues one block-aligned fetch request per
//  accepted cycle toward the L1 I-cache and arbitrates
//  exception > execute redirect > prediction > sequential.
//  Optional feature macro: PS_RAS_EN (return-address stack for predicted
//  calls/returns). Without it cagri/donus are ignored.
//  Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   istisna_gecerli_i/adres_i         trap redirect
//   yurut_yonlendir_gecerli_i/adres_i execute-stage correction
//   ongoru_gecerli_i/yuva_i/adres_i   predicted taken branch in current block
//   ongoru_cagri_i/donus_i            predicted branch is call / return
//   durdur_i                          fetch buffer full, hold request
//   l1b_istek_gecerli_o/hazir_i       L1I request handshake
//   l1b_adres_o                       block-aligned fetch address
//   ps_getir_o                        current PC
//   yuva_maske_o                      live slots of the block
//   yonlendirildi_o                   one-cycle pulse after a redirect
//   hizasiz_o                         misaligned redirect target (HATA state)
// ---------------------------------------------------------------------------
module ps_uretici_blok
  import ps_paket::*;
#(
  parameter int                         ADRES_GENISLIGI  = 32,
  parameter logic [ADRES_GENISLIGI-1:0] BASLANGIC_ADRESI = 32'h8000_0000,
  parameter int                         GETIR_GENISLIGI  = 2,
  parameter int                         RAS_DERINLIGI    = 4,
  localparam int                        SW = (GETIR_GENISLIGI > 1) ? $clog2(GETIR_GENISLIGI) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       istisna_gecerli_i,
  input  logic [ADRES_GENISLIGI-1:0] istisna_adres_i,
  input  logic                       yurut_yonlendir_gecerli_i,
  input  logic [ADRES_GENISLIGI-1:0] yurut_yonlendir_adres_i,
  input  logic                       ongoru_gecerli_i,
  input  logic [SW-1:0]              ongoru_yuva_i,
  input  logic [ADRES_GENISLIGI-1:0] ongoru_adres_i,
  input  logic                       ongoru_cagri_i,
  input  logic                       ongoru_donus_i,
  input  logic                       durdur_i,
  output logic                       l1b_istek_gecerli_o,
  input  logic                       l1b_istek_hazir_i,
  output logic [ADRES_GENISLIGI-1:0] l1b_adres_o,
  output logic [ADRES_GENISLIGI-1:0] ps_getir_o,
  output logic [GETIR_GENISLIGI-1:0] yuva_maske_o,
  output logic                       yonlendirildi_o,
  output logic                       hizasiz_o
);

  localparam int AG        = ADRES_GENISLIGI;
  localparam int GG        = GETIR_GENISLIGI;
  localparam int BLOK_BAYT = GG * BUYRUK_BAYT;
  localparam logic [AG-1:0] BLOK_MASKE = ~(AG'(BLOK_BAYT - 1));

  ps_durum_e durum;
  logic [AG-1:0] pc;
  logic          yonl_q;
  logic          hiz_q;

  logic [AG-1:0]        blok_taban;
  logic [AG-1:0]        sirali_adres;
  logic [AG-1:0]        yon_hedef;
  logic [AG-1:0]        ong_hedef;
  logic [AG-1:0]        ofs_ham;
  int                   ofs;
  logic                 ong_etkin;
  logic                 yon_var;
  logic                 gecerli;
  logic                 el_sik;
  logic [MASKE_MAX-1:0] maske_tam;

  always_comb begin
    blok_taban   = pc & BLOK_MASKE;
    sirali_adres = blok_taban + AG'(BLOK_BAYT);
    ofs_ham      = (pc >> $clog2(BUYRUK_BAYT)) & AG'(GG - 1);
    ofs          = int'(ofs_ham);
    // A predicted slot before the PC's own slot cannot be the branch we are
    // about to execute, so such a prediction is dropped.
    ong_etkin    = ongoru_gecerli_i && (int'(ongoru_yuva_i) >= ofs);
    yon_var      = istisna_gecerli_i || yurut_yonlendir_gecerli_i;
    yon_hedef    = istisna_gecerli_i ? istisna_adres_i : yurut_yonlendir_adres_i;
    gecerli      = (durum == GETIR) && !durdur_i;
    el_sik       = gecerli && l1b_istek_hazir_i;
    maske_tam    = yuva_maske(GG, ofs, ong_etkin, int'(ongoru_yuva_i));
  end

`ifdef PS_RAS_EN
  logic          ras_it;
  logic          ras_cek;
  logic          ras_bos;
  logic [AG-1:0] ras_ust;
  logic [AG-1:0] ras_it_adres;

  // Stack traffic only on an accepted block whose prediction is honoured;
  // redirects win and leave the stack untouched.
  assign ras_it       = el_sik && !yon_var && ong_etkin && ongoru_cagri_i;
  assign ras_cek      = el_sik && !yon_var && ong_etkin && ongoru_donus_i;
  assign ras_it_adres = blok_taban + AG'((int'(ongoru_yuva_i) + 1) * BUYRUK_BAYT);
  assign ong_hedef    = (ongoru_donus_i && !ras_bos) ? ras_ust : ongoru_adres_i;

  ps_yigin #(
    .ADRES_GENISLIGI (AG),
    .DERINLIK        (RAS_DERINLIGI)
  ) u_yigin (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .it_i       (ras_it),
    .cek_i      (ras_cek),
    .it_adres_i (ras_it_adres),
    .ust_o      (ras_ust),
    .bos_o      (ras_bos)
  );
`else
  localparam int unused_ras_derinligi = RAS_DERINLIGI;
  logic unused_ras_girisleri;
  assign unused_ras_girisleri = ongoru_cagri_i ^ ongoru_donus_i;
  assign ong_hedef            = ongoru_adres_i;
`endif

  // Stage p0 -> state: redirect wins regardless of handshake or stall.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum  <= BASLAT;
      pc     <= BASLANGIC_ADRESI;
      yonl_q <= 1'b0;
      hiz_q  <= 1'b0;
    end else begin
      yonl_q <= yon_var;
      if (yon_var) begin
        pc <= yon_hedef;
        if (|yon_hedef[1:0]) begin
          durum <= HATA;
          hiz_q <= 1'b1;
        end else begin
          durum <= GETIR;
          hiz_q <= 1'b0;
        end
      end else begin
        case (durum)
          BASLAT:  durum <= GETIR;
          GETIR:   if (el_sik) pc <= ong_etkin ? ong_hedef : sirali_adres;
          HATA:    durum <= HATA;
          default: durum <= BASLAT;
        endcase
      end
    end
  end

  always_comb begin
    l1b_istek_gecerli_o = gecerli;
    l1b_adres_o         = blok_taban;
    ps_getir_o          = pc;
    yuva_maske_o        = (durum == GETIR) ? maske_tam[GG-1:0] : '0;
    yonlendirildi_o     = yonl_q;
    hizasiz_o           = hiz_q;
  end

endmodule

// File: tb/tb_ps_uretici_blok.sv
// Bench for ps_uretici_blok (GG=2, reset PC 0x8000_0000).
module tb_ps_uretici_blok;

  localparam int          GG     = 2;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ist = 1'b0;
  logic [31:0] ist_adr = '0;
  logic        yur = 1'b0;
  logic [31:0] yur_adr = '0;
  logic        ong = 1'b0;
  logic [0:0]  ong_yuva = '0;
  logic [31:0] ong_adr = '0;
  logic        cagri = 1'b0;
  logic        donus = 1'b0;
  logic        durdur = 1'b0;
  logic        hazir = 1'b1;
  logic        gecerli;
  logic [31:0] l1b_adres;
  logic [31:0] ps;
  logic [1:0]  maske;
  logic        yonl;
  logic        hiz;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ps_uretici_blok dut (
    .clk_i                     (clk),
    .rst_i                     (rst),
    .istisna_gecerli_i         (ist),
    .istisna_adres_i           (ist_adr),
    .yurut_yonlendir_gecerli_i (yur),
    .yurut_yonlendir_adres_i   (yur_adr),
    .ongoru_gecerli_i          (ong),
    .ongoru_yuva_i             (ong_yuva),
    .ongoru_adres_i            (ong_adr),
    .ongoru_cagri_i            (cagri),
    .ongoru_donus_i            (donus),
    .durdur_i                  (durdur),
    .l1b_istek_gecerli_o       (gecerli),
    .l1b_istek_hazir_i         (hazir),
    .l1b_adres_o               (l1b_adres),
    .ps_getir_o                (ps),
    .yuva_maske_o              (maske),
    .yonlendirildi_o           (yonl),
    .hizasiz_o                 (hiz)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0=just out of reset, 1=fetching, 2=misaligned wait.
  logic [31:0] m_pc;
  int          m_faz;
  bit          m_pulse;
  bit          m_hiz;
  bit          m_ok = 0;
  logic [31:0] m_ras[$];

  always @(posedge clk) begin : model
    logic [31:0] t;
    int          o;
    if (rst) begin
      m_pc = RST_PC; m_faz = 0; m_pulse = 0; m_hiz = 0; m_ok = 1;
      m_ras.delete();
    end else if (m_ok) begin
      if (ist || yur) begin
        t = ist ? ist_adr : yur_adr;
        m_pc = t; m_pulse = 1;
        if (t % 4 != 0) begin m_faz = 2; m_hiz = 1; end
        else begin m_faz = 1; m_hiz = 0; end
      end else begin
        m_pulse = 0;
        if (m_faz == 0) m_faz = 1;
        else if (m_faz == 1 && !durdur && hazir) begin
          o = int'((m_pc / 4) % GG);
          if (ong && int'(ong_yuva) >= o) begin
            t = ong_adr;
`ifdef PS_RAS_EN
            if (donus && m_ras.size() > 0) begin
              t = m_ras[$];
              void'(m_ras.pop_back());
            end
            if (cagri) begin
              m_ras.push_back(m_pc - (m_pc % (GG * 4)) + 4 * int'(ong_yuva) + 4);
              if (m_ras.size() > 4) void'(m_ras.pop_front());
            end
`endif
            m_pc = t;
          end else begin
            m_pc = m_pc - (m_pc % (GG * 4)) + GG * 4;
          end
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [1:0] em;
    int         o;
    if (m_ok) begin
      o  = int'((m_pc / 4) % GG);
      em = '0;
      if (m_faz == 1)
        for (int i = 0; i < GG; i++)
          if (i >= o && (!(ong && int'(ong_yuva) >= o) || i <= int'(ong_yuva))) em[i] = 1'b1;
      chk("m_valid", 32'(gecerli), 32'(m_faz == 1 && !durdur));
      chk("m_addr", l1b_adres, m_pc - (m_pc % (GG * 4)));
      chk("m_pc", ps, m_pc);
      chk("m_mask", 32'(maske), 32'(em));
      chk("m_pulse", 32'(yonl), 32'(m_pulse));
      chk("m_hiz", 32'(hiz), 32'(m_hiz));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(gecerli), 0);
    chk("rst_pc", ps, 32'h8000_0000);
    chk("rst_addr", l1b_adres, 32'h8000_0000);
    chk("rst_mask", 32'(maske), 0);
    chk("rst_pulse", 32'(yonl), 0);
    step();
    @(negedge clk);
    chk("first_addr", l1b_adres, 32'h8000_0000);
    chk("first_mask", 32'(maske), 32'h3);
    chk("first_valid", 32'(gecerli), 1);
    step();
    hazir = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_addr", l1b_adres, 32'h8000_0008);
      chk("hold_valid", 32'(gecerli), 1);
      step();
    end
    hazir = 1'b1;
    step();
    ong = 1'b1; ong_yuva = 1'b0; ong_adr = 32'h8000_0400;
    @(negedge clk);
    chk("seq3_addr", l1b_adres, 32'h8000_0010);
    chk("pred_mask", 32'(maske), 32'h1);
    step();
    ong = 1'b0;
    @(negedge clk);
    chk("pred_pc", ps, 32'h8000_0400);
    yur = 1'b1; yur_adr = 32'h8000_0104;
    step();
    yur = 1'b0; hazir = 1'b0;
    @(negedge clk);
    chk("yur_pulse", 32'(yonl), 1);
    chk("yur_addr", l1b_adres, 32'h8000_0100);
    chk("yur_pc", ps, 32'h8000_0104);
    chk("yur_mask", 32'(maske), 32'h2);
    step();
    @(negedge clk);
    chk("pulse_end", 32'(yonl), 0);
    ist = 1'b1; ist_adr = 32'h8000_0200; yur = 1'b1; yur_adr = 32'h8000_0300;
    step();
    ist = 1'b0; yur = 1'b0;
    @(negedge clk);
    chk("ist_prio", ps, 32'h8000_0200);
    yur = 1'b1; yur_adr = 32'h8000_0102;
    step();
    yur = 1'b0;
    @(negedge clk);
    chk("hata_valid", 32'(gecerli), 0);
    chk("hata_hiz", 32'(hiz), 1);
    step();
    @(negedge clk);
    chk("hata_hold", 32'(hiz), 1);
    yur = 1'b1; yur_adr = 32'h8000_0100;
    step();
    yur = 1'b0;
    @(negedge clk);
    chk("recover_hiz", 32'(hiz), 0);
    chk("recover_valid", 32'(gecerli), 1);
    durdur = 1'b1;
    @(negedge clk);
    chk("stall_valid", 32'(gecerli), 0);
    step();
    durdur = 1'b0;
    yur = 1'b1; yur_adr = 32'hFFFF_FFF8;
    step();
    yur = 1'b0; hazir = 1'b1;
    step();
    @(negedge clk);
    chk("wrap_pc", ps, 32'h0000_0000);
    yur = 1'b1; yur_adr = 32'h8000_0104;
    step();
    yur = 1'b0; ong = 1'b1; ong_yuva = 1'b0; ong_adr = 32'h8000_0700;
    @(negedge clk);
    chk("early_pred_mask", 32'(maske), 32'h2);
    step();
    ong = 1'b0;
    @(negedge clk);
    chk("early_pred_pc", ps, 32'h8000_0108);
    yur = 1'b1; yur_adr = 32'h8000_0010;
    step();
    yur = 1'b0; ong = 1'b1; ong_yuva = 1'b0; cagri = 1'b1; ong_adr = 32'h8000_0600;
    step();
    cagri = 1'b0; donus = 1'b1; ong_adr = 32'h8000_0900;
    step();
    ong = 1'b0; donus = 1'b0;
    @(negedge clk);
`ifdef PS_RAS_EN
    chk("ras_return", ps, 32'h8000_0014);
`else
    chk("ret_no_ras", ps, 32'h8000_0900);
`endif
    rst = 1'b1;
    step();
    rst = 1'b0; yur = 1'b1; yur_adr = 32'h8000_0500;
    @(negedge clk);
    chk("midrst_pulse", 32'(yonl), 0);
    chk("midrst_pc", ps, 32'h8000_0000);
    step();
    yur = 1'b0;
    @(negedge clk);
    chk("baslat_redir_pc", ps, 32'h8000_0500);
    chk("baslat_redir_valid", 32'(gecerli), 1);
    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
